// File: rtl/hazard_pkg.sv
// Shared opcodes, forwarding-select encodings and the in-flight write record
// used by the hazard scoreboard and its operand comparator.
package hazard_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_LD   = 4'd10;
    localparam logic [3:0] OP_ST   = 4'd11;
    localparam logic [3:0] OP_BZ   = 4'd12;

    localparam int unsigned FWD_RF  = 0;
    localparam int unsigned FWD_EX  = 1;
    localparam int unsigned FWD_MEM = 2;
    localparam int unsigned FWD_WB  = 3;

    // Destination field is sized for the widest supported register file;
    // narrower addresses are stored zero-extended.
    localparam int unsigned REG_AW_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] dest;
        logic                  is_ld;
    } inflight_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage operand/control bundle and hazard results exchanged between the
// decode stage (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int unsigned REG_AW = 3,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned SEL_W  = 2
);
    logic              id_valid;
    logic [OP_W-1:0]   id_opcode;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_use1;
    logic              id_use2;
    logic [REG_AW-1:0] id_dest;
    logic              id_wr;
    logic              freeze;
    logic              flush;
    logic              cnt_clr;
    logic              stall;
    logic [SEL_W-1:0]  fwd_sel1;
    logic [SEL_W-1:0]  fwd_sel2;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_opcode, id_src1, id_src2, id_use1, id_use2,
               id_dest, id_wr, freeze, flush, cnt_clr,
        input  stall, fwd_sel1, fwd_sel2, stall_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_src1, id_src2, id_use1, id_use2,
               id_dest, id_wr, freeze, flush, cnt_clr,
        output stall, fwd_sel1, fwd_sel2, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Single-operand comparator: flags every in-flight stage writing the operand
// and reports the youngest such stage (0 = register file).
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 3,
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned SEL_W      = 2
) (
    input  logic              i_use,
    input  logic [REG_AW-1:0] i_src,
    input  inflight_t         i_ent [1:PIPE_DEPTH],
    output logic [PIPE_DEPTH:1] o_hit,
    output logic [SEL_W-1:0]  o_youngest
);

    always_comb begin
        o_hit      = '0;
        o_youngest = SEL_W'(FWD_RF);
        // Scan oldest to youngest so the last hit written is the youngest.
        for (int unsigned k = PIPE_DEPTH; k >= 1; k--) begin
            if (i_use && (i_src != '0) && i_ent[k].valid &&
                (i_ent[k].dest == REG_AW_MAX'(i_src))) begin
                o_hit[k]   = 1'b1;
                o_youngest = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Self-tracking hazard unit: shifts a record of in-flight register writes
// down the pipeline and derives stall, forwarding selects and a stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 3,
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned OP_W       = 4,
    parameter int unsigned OP_NOP     = 0,
    parameter int unsigned OP_LD      = 10,
    parameter int unsigned OP_BZ      = 12,
    parameter int unsigned FWD_EN     = 1,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
    input logic clk,
    input logic rst,
    hazard_scoreboard_if.slave bus
);

    inflight_t          r_ent [1:PIPE_DEPTH];
    logic [CNT_W-1:0]   r_cnt;

    logic [PIPE_DEPTH:1] w_hit1;
    logic [PIPE_DEPTH:1] w_hit2;
    logic [PIPE_DEPTH:1] w_any;
    logic [SEL_W-1:0]    w_sel1;
    logic [SEL_W-1:0]    w_sel2;
    logic                w_is_nop;
    logic                w_is_bz;
    logic                w_raw;
    logic                w_stall;

    hazard_match #(
        .REG_AW     (REG_AW),
        .PIPE_DEPTH (PIPE_DEPTH),
        .SEL_W      (SEL_W)
    ) u_match1 (
        .i_use      (bus.id_use1),
        .i_src      (bus.id_src1),
        .i_ent      (r_ent),
        .o_hit      (w_hit1),
        .o_youngest (w_sel1)
    );

    hazard_match #(
        .REG_AW     (REG_AW),
        .PIPE_DEPTH (PIPE_DEPTH),
        .SEL_W      (SEL_W)
    ) u_match2 (
        .i_use      (bus.id_use2),
        .i_src      (bus.id_src2),
        .i_ent      (r_ent),
        .o_hit      (w_hit2),
        .o_youngest (w_sel2)
    );

    always_comb begin
        w_any    = w_hit1 | w_hit2;
        w_is_nop = (bus.id_opcode == OP_W'(OP_NOP));
        w_is_bz  = (bus.id_opcode == OP_W'(OP_BZ));
        if (FWD_EN != 0) begin
            // Load-use, branch vs any EX writer, branch vs load in MEM.
            w_raw = (!w_is_nop && !w_is_bz && w_any[1] && r_ent[1].is_ld) ||
                    (w_is_bz && w_any[1]) ||
                    (w_is_bz && w_any[2] && r_ent[2].is_ld);
        end else begin
            w_raw = |w_any;
        end
        w_stall = bus.id_valid && !bus.flush && w_raw;

        bus.stall     = w_stall;
        bus.fwd_sel1  = SEL_W'(FWD_RF);
        bus.fwd_sel2  = SEL_W'(FWD_RF);
        bus.stall_cnt = r_cnt;
        if ((FWD_EN != 0) && bus.id_valid && !w_stall) begin
            bus.fwd_sel1 = w_sel1;
            bus.fwd_sel2 = w_sel2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 1; k <= PIPE_DEPTH; k++) begin
                r_ent[k] <= '0;
            end
        end else if (!bus.freeze) begin
            for (int unsigned k = 2; k <= PIPE_DEPTH; k++) begin
                r_ent[k] <= r_ent[k-1];
            end
            // A stalled or flushed ID instruction enters EX as a bubble.
            r_ent[1].valid <= bus.id_valid && bus.id_wr && (bus.id_dest != '0) &&
                              !w_stall && !bus.flush;
            r_ent[1].dest  <= REG_AW_MAX'(bus.id_dest);
            r_ent[1].is_ld <= (bus.id_opcode == OP_W'(OP_LD));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_cnt <= '0;
        end else if (w_stall && !bus.freeze && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one forwarding instance and one
// no-forwarding instance with a narrow counter for saturation.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(3), .OP_W(4), .CNT_W(16), .SEL_W(2)) bf ();
    hazard_scoreboard_if #(.REG_AW(3), .OP_W(4), .CNT_W(4),  .SEL_W(2)) bn ();

    hazard_scoreboard #(
        .REG_AW(3), .PIPE_DEPTH(3), .OP_W(4), .OP_NOP(0), .OP_LD(10), .OP_BZ(12),
        .FWD_EN(1), .CNT_W(16), .SEL_W(2)
    ) u_fwd (.clk(clk), .rst(rst), .bus(bf));

    hazard_scoreboard #(
        .REG_AW(3), .PIPE_DEPTH(3), .OP_W(4), .OP_NOP(0), .OP_LD(10), .OP_BZ(12),
        .FWD_EN(0), .CNT_W(4), .SEL_W(2)
    ) u_nofwd (.clk(clk), .rst(rst), .bus(bn));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit nf, input logic v, input logic [3:0] op,
                       input logic [2:0] s1, input logic u1,
                       input logic [2:0] s2, input logic u2,
                       input logic [2:0] d, input logic wr);
        if (nf) begin
            bn.id_valid = v;  bn.id_opcode = op; bn.id_src1 = s1; bn.id_use1 = u1;
            bn.id_src2 = s2;  bn.id_use2 = u2;   bn.id_dest = d;  bn.id_wr = wr;
            bn.freeze = 1'b0; bn.flush = 1'b0;   bn.cnt_clr = 1'b0;
        end else begin
            bf.id_valid = v;  bf.id_opcode = op; bf.id_src1 = s1; bf.id_use1 = u1;
            bf.id_src2 = s2;  bf.id_use2 = u2;   bf.id_dest = d;  bf.id_wr = wr;
            bf.freeze = 1'b0; bf.flush = 1'b0;   bf.cnt_clr = 1'b0;
        end
        #1;
    endtask

    task automatic drain();
        drv(1'b0, 1'b0, OP_NOP, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        drv(1'b1, 1'b0, OP_NOP, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        drain();
        rst = 1'b0;
        drv(1'b0, 1'b1, OP_ADDI, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1);
        tick();
        rst = 1'b1;
        drv(1'b0, 1'b0, OP_NOP, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        rst = 1'b0;
        n_tests++;
        if (bf.stall !== 1'b0) begin n_fail++; $display("FAIL reset_idle_stall: got %0b want 0", bf.stall); end
        n_tests++;
        if (bf.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bf.stall_cnt); end
        n_tests++;
        if (bn.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt_nf: got %0d want 0", bn.stall_cnt); end
        drv(1'b0, 1'b1, OP_ADDI, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        n_tests++;
        if (bf.fwd_sel1 !== 2'd0) begin n_fail++; $display("FAIL reset_discard_sel1: got %0d want 0", bf.fwd_sel1); end
        n_tests++;
        if (bf.stall !== 1'b0) begin n_fail++; $display("FAIL reset_discard_stall: got %0b want 0", bf.stall); end
    endtask

    task automatic test_fwd_ex();
        drain();
        drv(1'b0, 1'b1, OP_ADDI, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1);
        tick();
        drv(1'b0, 1'b1, OP_ADDI, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1);
        n_tests++;
        if (bf.stall !== 1'b0) begin n_fail++; $display("FAIL fwd_ex_stall: got %0b want 0", bf.stall); end
        n_tests++;
        if (bf.fwd_sel1 !== 2'd1) begin n_fail++; $display("FAIL fwd_ex_sel1: got %0d want 1", bf.fwd_sel1); end
        n_tests++;
        if (bf.fwd_sel2 !== 2'd0) begin n_fail++; $display("FAIL fwd_ex_sel2: got %0d want 0", bf.fwd_sel2); end
        tick();
    endtask

    task automatic test_load_use();
        drain();
        drv(1'b0, 1'b0, OP_NOP, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        bf.cnt_clr = 1'b1;
        tick();
        drv(1'b0, 1'b1, OP_LD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1);
        n_tests++;
        if (bf.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL ld_cnt_clr: got %0d want 0", bf.stall_cnt); end
        tick();
        drv(1'b0, 1'b1, OP_NOP, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        n_tests++;
        if (bf.stall !== 1'b0) begin n_fail++; $display("FAIL ld_nop_exempt: got %0b want 0", bf.stall); end
        drv(1'b0, 1'b1, OP_ADDI, 3'd2, 1'b1, 3'd0, 1'b1, 3'd5, 1'b1);
        n_tests++;
        if (bf.stall !== 1'b1) begin n_fail++; $display("FAIL ld_use_stall: got %0b want 1", bf.stall); end
        n_tests++;
        if (bf.fwd_sel1 !== 2'd0) begin n_fail++; $display("FAIL ld_use_sel_forced: got %0d want 0", bf.fwd_sel1); end
        tick();
        n_tests++;
        if (bf.stall !== 1'b0) begin n_fail++; $display("FAIL ld_use_release: got %0b want 0", bf.stall); end
        n_tests++;
        if (bf.fwd_sel1 !== 2'd2) begin n_fail++; $display("FAIL ld_use_sel_mem: got %0d want 2", bf.fwd_sel1); end
        n_tests++;
        if (bf.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL ld_use_cnt: got %0d want 1", bf.stall_cnt); end
        tick();
    endtask

    task automatic test_branch_ex();
        drain();
        drv(1'b0, 1'b1, OP_ADDI, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1);
        tick();
        drv(1'b0, 1'b1, OP_BZ, 3'd5, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        n_tests++;
        if (bf.stall !== 1'b1) begin n_fail++; $display("FAIL bz_ex_stall: got %0b want 1", bf.stall); end
        tick();
        n_tests++;
        if (bf.stall !== 1'b0) begin n_fail++; $display("FAIL bz_mem_alu_nostall: got %0b want 0", bf.stall); end
        n_tests++;
        if (bf.fwd_sel1 !== 2'd2) begin n_fail++; $display("FAIL bz_mem_sel1: got %0d want 2", bf.fwd_sel1); end
        tick();
    endtask

    task automatic test_branch_ld();
        drain();
        drv(1'b0, 1'b1, OP_LD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1);
        tick();
        drv(1'b0, 1'b1, OP_BZ, 3'd5, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        n_tests++;
        if (bf.stall !== 1'b1) begin n_fail++; $display("FAIL bz_ld_c1: got %0b want 1", bf.stall); end
        tick();
        n_tests++;
        if (bf.stall !== 1'b1) begin n_fail++; $display("FAIL bz_ld_c2: got %0b want 1", bf.stall); end
        tick();
        n_tests++;
        if (bf.stall !== 1'b0) begin n_fail++; $display("FAIL bz_ld_c3: got %0b want 0", bf.stall); end
        n_tests++;
        if (bf.fwd_sel1 !== 2'd3) begin n_fail++; $display("FAIL bz_ld_sel_wb: got %0d want 3", bf.fwd_sel1); end
        tick();
    endtask

    task automatic test_youngest();
        drain();
        drv(1'b0, 1'b1, OP_ADDI, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1);
        tick();
        drv(1'b0, 1'b1, OP_ADDI, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1);
        tick();
        tick();
        drv(1'b0, 1'b1, OP_ADDI, 3'd4, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0);
        n_tests++;
        if (bf.fwd_sel1 !== 2'd3) begin n_fail++; $display("FAIL young_sel1_wb: got %0d want 3", bf.fwd_sel1); end
        n_tests++;
        if (bf.fwd_sel2 !== 2'd1) begin n_fail++; $display("FAIL young_sel2_ex: got %0d want 1", bf.fwd_sel2); end
        tick();
        drv(1'b0, 1'b1, OP_ADDI, 3'd3, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0);
        n_tests++;
        if (bf.fwd_sel1 !== 2'd2) begin n_fail++; $display("FAIL young_sel1_mem: got %0d want 2", bf.fwd_sel1); end
        n_tests++;
        if (bf.fwd_sel2 !== 2'd0) begin n_fail++; $display("FAIL young_unused_sel2: got %0d want 0", bf.fwd_sel2); end
        tick();
        n_tests++;
        if (bf.fwd_sel1 !== 2'd3) begin n_fail++; $display("FAIL young_sel1_old: got %0d want 3", bf.fwd_sel1); end
        tick();
        n_tests++;
        if (bf.fwd_sel1 !== 2'd0) begin n_fail++; $display("FAIL young_retired: got %0d want 0", bf.fwd_sel1); end
    endtask

    task automatic test_zero_src();
        drain();
        drv(1'b0, 1'b1, OP_LD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
        tick();
        drv(1'b0, 1'b1, OP_ADDI, 3'd0, 1'b1, 3'd0, 1'b1, 3'd1, 1'b1);
        n_tests++;
        if (bf.stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %0b want 0", bf.stall); end
        n_tests++;
        if ({bf.fwd_sel1, bf.fwd_sel2} !== 4'd0) begin n_fail++; $display("FAIL r0_sel: got %0d/%0d want 0/0", bf.fwd_sel1, bf.fwd_sel2); end
        tick();
    endtask

    task automatic test_flush();
        drain();
        drv(1'b0, 1'b1, OP_LD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1);
        tick();
        drv(1'b0, 1'b0, OP_ADDI, 3'd2, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1);
        n_tests++;
        if (bf.stall !== 1'b0) begin n_fail++; $display("FAIL invalid_stall: got %0b want 0", bf.stall); end
        n_tests++;
        if (bf.fwd_sel1 !== 2'd0) begin n_fail++; $display("FAIL invalid_sel1: got %0d want 0", bf.fwd_sel1); end
        drv(1'b0, 1'b1, OP_ADDI, 3'd2, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1);
        bf.flush = 1'b1;
        #1;
        n_tests++;
        if (bf.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %0b want 0", bf.stall); end
        tick();
        drv(1'b0, 1'b1, OP_ADDI, 3'd3, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0);
        n_tests++;
        if (bf.stall !== 1'b0) begin n_fail++; $display("FAIL flush_after_stall: got %0b want 0", bf.stall); end
        n_tests++;
        if (bf.fwd_sel1 !== 2'd0) begin n_fail++; $display("FAIL flush_killed_write: got %0d want 0", bf.fwd_sel1); end
        n_tests++;
        if (bf.fwd_sel2 !== 2'd2) begin n_fail++; $display("FAIL flush_ld_mem_sel2: got %0d want 2", bf.fwd_sel2); end
        tick();
    endtask

    task automatic test_freeze();
        drain();
        drv(1'b0, 1'b0, OP_NOP, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        bf.cnt_clr = 1'b1;
        tick();
        drv(1'b0, 1'b1, OP_LD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1);
        tick();
        drv(1'b0, 1'b1, OP_ADDI, 3'd2, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1);
        bf.freeze = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (bf.stall !== 1'b1) begin n_fail++; $display("FAIL freeze_stall[%0d]: got %0b want 1", i, bf.stall); end
            n_tests++;
            if (bf.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL freeze_cnt[%0d]: got %0d want 0", i, bf.stall_cnt); end
        end
        bf.freeze = 1'b0;
        tick();
        n_tests++;
        if (bf.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL unfreeze_cnt: got %0d want 1", bf.stall_cnt); end
        n_tests++;
        if (bf.fwd_sel1 !== 2'd2) begin n_fail++; $display("FAIL unfreeze_sel1: got %0d want 2", bf.fwd_sel1); end
        tick();
    endtask

    task automatic test_nofwd();
        drain();
        drv(1'b1, 1'b1, OP_ADDI, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1);
        tick();
        drv(1'b1, 1'b1, OP_ADDI, 3'd6, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (bn.stall !== 1'b1) begin n_fail++; $display("FAIL nofwd_stall[%0d]: got %0b want 1", i, bn.stall); end
            n_tests++;
            if (bn.fwd_sel1 !== 2'd0) begin n_fail++; $display("FAIL nofwd_sel1[%0d]: got %0d want 0", i, bn.fwd_sel1); end
            tick();
        end
        n_tests++;
        if (bn.stall !== 1'b0) begin n_fail++; $display("FAIL nofwd_release: got %0b want 0", bn.stall); end
        n_tests++;
        if (bn.stall_cnt !== 4'd3) begin n_fail++; $display("FAIL nofwd_cnt: got %0d want 3", bn.stall_cnt); end
        tick();
    endtask

    task automatic nf_round();
        drv(1'b1, 1'b1, OP_ADDI, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1);
        tick();
        drv(1'b1, 1'b1, OP_ADDI, 3'd6, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_saturate();
        drain();
        repeat (4) nf_round();
        n_tests++;
        if (bn.stall_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_reach: got %0d want 15", bn.stall_cnt); end
        nf_round();
        n_tests++;
        if (bn.stall_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_hold: got %0d want 15", bn.stall_cnt); end
        drv(1'b1, 1'b1, OP_ADDI, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1);
        tick();
        drv(1'b1, 1'b1, OP_ADDI, 3'd6, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        bn.cnt_clr = 1'b1;
        #1;
        tick();
        n_tests++;
        if (bn.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_over_inc: got %0d want 0", bn.stall_cnt); end
        bn.cnt_clr = 1'b0;
        tick();
        n_tests++;
        if (bn.stall_cnt !== 4'd1) begin n_fail++; $display("FAIL cnt_after_clr: got %0d want 1", bn.stall_cnt); end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drv(1'b0, 1'b0, OP_NOP, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        drv(1'b1, 1'b0, OP_NOP, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        test_reset();
        test_fwd_ex();
        test_load_use();
        test_branch_ex();
        test_branch_ld();
        test_youngest();
        test_zero_src();
        test_flush();
        test_freeze();
        test_nofwd();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
